// File: rtl/regfile_sb.sv
// Integer register file: two combinational read ports, two write ports (port 1 wins on a
// same-address collision), optional write-to-read bypass and a per-register busy scoreboard
// with a registered count of busy registers for RAW hazard detection in decode.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic              o_rs1_busy,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_rs2_busy,
  input  logic              i_wr0_en,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  input  logic              i_wr1_en,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  input  logic              i_issue_en,
  input  logic [ADDR_W-1:0] i_issue_addr,
  output logic [ADDR_W:0]   o_busy_cnt
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam bit          ZeroEn   = (ZERO_REG != 0);
  localparam bit          BypassEn = (BYPASS != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                wr0_ok, wr1_ok, issue_ok;

  // Bypassed read of one port; x0 is hard-wired to zero before any forwarding.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
    if (BypassEn && i_wr0_en && (i_wr0_addr == addr)) val = i_wr0_data;
    if (BypassEn && i_wr1_en && (i_wr1_addr == addr)) val = i_wr1_data;
    if (ZeroEn && (addr == '0)) val = '0;
    return val;
  endfunction

  // A same-cycle writeback hides the busy bit only when its data is being forwarded.
  function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
    logic hit;
    hit = (i_wr0_en && (i_wr0_addr == addr)) || (i_wr1_en && (i_wr1_addr == addr));
    return busy_q[addr] & ~(BypassEn & hit);
  endfunction

  // Qualify writes and issue against the hard-wired zero register.
  always_comb begin
    wr0_ok   = i_wr0_en & ~(ZeroEn && (i_wr0_addr == '0));
    wr1_ok   = i_wr1_en & ~(ZeroEn && (i_wr1_addr == '0));
    issue_ok = i_issue_en & ~(ZeroEn && (i_issue_addr == '0));
  end

  // Next-state for storage, scoreboard and busy count; later assignments take priority.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[i_wr0_addr] = i_wr0_data;
      busy_d[i_wr0_addr] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[i_wr1_addr] = i_wr1_data;
      busy_d[i_wr1_addr] = 1'b0;
    end
    // A new producer issued alongside the old one's writeback keeps the register busy.
    if (issue_ok) busy_d[i_issue_addr] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + (ADDR_W + 1)'(busy_d[i]);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    o_rs1_data = read_port(i_rs1_addr);
    o_rs2_data = read_port(i_rs2_addr);
    o_rs1_busy = read_busy(i_rs1_addr);
    o_rs2_busy = read_busy(i_rs2_addr);
    o_busy_cnt = cnt_q;
  end

endmodule
